// File: rtl/seq_multiplier_if.sv
// seq_multiplier_if: request/result bundle for seq_multiplier
//   start       request, sampled only while the multiplier is idle
//   signed_mode 0 = unsigned operands, 1 = two's-complement operands
//   a_in, b_in  W-bit operands, sampled with start
//   busy        high from the capture edge through the done cycle
//   done        one-cycle completion pulse
//   product     2W-bit registered result, held until the next done
interface seq_multiplier_if #(parameter int W = 8);
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a_in;
    logic [W-1:0]   b_in;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    modport master (output start, signed_mode, a_in, b_in, input busy, done, product);
    modport slave  (input start, signed_mode, a_in, b_in, output busy, done, product);
endinterface

// File: rtl/seq_multiplier.sv
// seq_multiplier: shift-and-add multiplier with early termination on the smaller magnitude
//   clk_100MHz  system clock, rising edge
//   reset       asynchronous active-high reset
//   bus         seq_multiplier_if slave: start/signed_mode/a_in/b_in in, busy/done/product out
module seq_multiplier #(
    parameter int W = 8
) (
    input logic             clk_100MHz,
    input logic             reset,
    seq_multiplier_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q;
    logic [W-1:0]   m_q;
    logic [2*W-1:0] d_q;
    logic [2*W-1:0] acc_q;
    logic [2*W-1:0] product_q;
    logic           neg_q;
    logic           busy_q;
    logic           done_q;

    logic [W-1:0]   mag_a_d;
    logic [W-1:0]   mag_b_d;
    logic           neg_d;
    logic           a_smaller_d;

    // Negating the most negative value wraps back to 2^(W-1), which is the
    // correct magnitude when read as unsigned.
    always_comb begin
        mag_a_d     = (bus.signed_mode && bus.a_in[W-1]) ? -bus.a_in : bus.a_in;
        mag_b_d     = (bus.signed_mode && bus.b_in[W-1]) ? -bus.b_in : bus.b_in;
        neg_d       = bus.signed_mode & (bus.a_in[W-1] ^ bus.b_in[W-1]);
        a_smaller_d = mag_a_d < mag_b_d;
    end

    // The smaller magnitude drives the iteration count, so latency tracks its bit length.
    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            m_q       <= '0;
            d_q       <= '0;
            acc_q     <= '0;
            product_q <= '0;
            neg_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        m_q     <= a_smaller_d ? mag_a_d : mag_b_d;
                        d_q     <= {{W{1'b0}}, (a_smaller_d ? mag_b_d : mag_a_d)};
                        acc_q   <= '0;
                        neg_q   <= neg_d;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (m_q != '0) begin
                        acc_q <= acc_q + (m_q[0] ? d_q : '0);
                        d_q   <= d_q << 1;
                        m_q   <= m_q >> 1;
                    end else begin
                        product_q <= neg_q ? -acc_q : acc_q;
                        done_q    <= 1'b1;
                        state_q   <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: directed checks of seq_multiplier at W=8
module tb_seq_multiplier;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    seq_multiplier_if #(.W(8)) bus ();
    seq_multiplier #(.W(8)) dut (.clk_100MHz(clk), .reset(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Captures one operation, scrambles the operands afterwards, and checks the
    // busy/done timeline: done appears only in the cycle after edge k+1.
    task automatic run(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sm,
                       input int k, input logic [15:0] exp, input logic poke);
        bus.start = 1'b1;
        bus.a_in = a;
        bus.b_in = b;
        bus.signed_mode = sm;
        tick;
        bus.start = poke;
        bus.a_in = ~a;
        bus.b_in = b ^ 8'h5A;
        bus.signed_mode = ~sm;
        check({tag, " capture"}, {30'd0, bus.busy, bus.done}, 32'd2);
        for (int i = 1; i <= k; i++) begin
            tick;
            bus.start = 1'b0;
            check({tag, " run"}, {30'd0, bus.busy, bus.done}, 32'd2);
        end
        tick;
        bus.start = 1'b0;
        check({tag, " done"}, {30'd0, bus.busy, bus.done}, 32'd3);
        check({tag, " product"}, {16'd0, bus.product}, {16'd0, exp});
        tick;
        check({tag, " idle"}, {30'd0, bus.busy, bus.done}, 32'd0);
        check({tag, " held"}, {16'd0, bus.product}, {16'd0, exp});
        tick;
        check({tag, " no requeue"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.signed_mode = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        #2;
        check("reset outputs", {14'd0, bus.busy, bus.done, bus.product}, 32'd0);
        tick;
        tick;
        check("reset held", {14'd0, bus.busy, bus.done, bus.product}, 32'd0);
        #3 rst = 1'b0;
        tick;

        run("u13x11",   8'd13,  8'd11,  1'b0, 4, 16'h008F, 1'b0);
        run("u255x255", 8'd255, 8'd255, 1'b0, 8, 16'hFE01, 1'b0);
        run("u0x200",   8'd0,   8'd200, 1'b0, 0, 16'h0000, 1'b0);
        run("sm128",    8'h80,  8'h80,  1'b1, 8, 16'h4000, 1'b0);
        run("sm3x7",    8'hFD,  8'd7,   1'b1, 2, 16'hFFEB, 1'b0);
        run("s5xm1",    8'd5,   8'hFF,  1'b1, 1, 16'hFFFB, 1'b0);
        run("u128x2",   8'h80,  8'd2,   1'b0, 2, 16'h0100, 1'b0);
        run("u200x3",   8'd200, 8'd3,   1'b0, 2, 16'h0258, 1'b0);
        run("busy poke", 8'd13, 8'd11,  1'b0, 4, 16'h008F, 1'b1);

        // start held high: a second operation begins one cycle after done
        bus.start = 1'b1;
        bus.a_in = 8'd2;
        bus.b_in = 8'd3;
        bus.signed_mode = 1'b0;
        tick;
        tick;
        tick;
        tick;
        check("held done1", {30'd0, bus.busy, bus.done}, 32'd3);
        check("held prod1", {16'd0, bus.product}, 32'h6);
        tick;
        check("held gap", {30'd0, bus.busy, bus.done}, 32'd0);
        bus.a_in = 8'd7;
        tick;
        bus.start = 1'b0;
        check("held recapture", {30'd0, bus.busy, bus.done}, 32'd2);
        tick;
        tick;
        tick;
        check("held done2", {30'd0, bus.busy, bus.done}, 32'd3);
        check("held prod2", {16'd0, bus.product}, 32'h15);
        tick;
        tick;

        // asynchronous reset in the middle of a run
        bus.start = 1'b1;
        bus.a_in = 8'd255;
        bus.b_in = 8'd255;
        tick;
        bus.start = 1'b0;
        tick;
        tick;
        #2 rst = 1'b1;
        #1;
        check("abort outputs", {14'd0, bus.busy, bus.done, bus.product}, 32'd0);
        #2 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick;
            check("abort quiet", {14'd0, bus.busy, bus.done, bus.product}, 32'd0);
        end
        run("after abort", 8'd13, 8'd11, 1'b0, 4, 16'h008F, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
